downsample_engine: RTL and testbench
====================================

Name: downsample_engine

Overview:
- Hardwired, parametrised successor to the microcoded downsampling processor.
- Reads a square source image from byte-addressed DRAM and reduces each FxF pixel block to one output pixel, either by averaging or by decimation.
- Writes the reduced image back to DRAM.
- Drops into the existing DRAM interface: addr_out, dout, d_in, read, write, finish.

Parameters:
- DATA_W, 8: pixel and DRAM data width.
- ADDR_W, 16: DRAM address width.
- IMG_DIM, 128: source image side in pixels. Must be a power of 2 and divisible by 2**FACTOR_LOG2.
- FACTOR_LOG2, 1: log2 of the downsample factor F. F = 2**FACTOR_LOG2; 0 is illegal.
- SRC_BASE, 16'h0000: address of source pixel (0,0). The source image is stored row-major.
- DST_BASE, 16'h4000: address of output pixel (0,0). Output is row-major with side OUT_DIM = IMG_DIM/F.
- MEM_LAT, 1: number of cycles from read being asserted to d_in being valid (>=1).

Ports:
- clk, in, 1: single clock; all state changes on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- enable, in, 1: level start/run request.
- mode, in, 1: 0 = average, 1 = decimate (top-left pixel of each block). Sampled at start.
- d_in, in, DATA_W: DRAM read data.
- addr_out, out, ADDR_W: DRAM address.
- dout, out, DATA_W: DRAM write data.
- read, out, 1: one-cycle DRAM read strobe.
- write, out, 1: one-cycle DRAM write strobe.
- busy, out, 1: high in every state except IDLE and DONE.
- finish, out, 1: high in DONE.

Behaviour:
- Reset: takes priority over everything. Next edge enters IDLE; all counters and the accumulator go to 0. addr_out=0, dout=0, read=0, write=0, busy=0, finish=0. Reset mid-operation aborts with no further write.
- States: IDLE, RD, WAIT, WR, DONE.
- IDLE: when enable=1 at an edge, latch mode, clear counters and accumulator, go to RD.
- RD, one cycle: read=1, addr_out = SRC_BASE + (oy*F+ky)*IMG_DIM + ox*F + kx. Then go to WAIT.
- WAIT: lasts MEM_LAT cycles. On the edge ending the last WAIT cycle, capture d_in:
  - average: acc += d_in;
  - decimate: acc = d_in.
- After the capture:
  - average: if (kx,ky) is not (F-1,F-1), advance kx (wrapping into ky) and go to RD; otherwise go to WR.
  - decimate: always go to WR (only kx=ky=0 is read).
- WR, one cycle: write=1, addr_out = DST_BASE + oy*OUT_DIM + ox, dout = result.
  - average result: (acc + 2**(2*FACTOR_LOG2-1)) >> (2*FACTOR_LOG2), i.e. round half up. Accumulator width is DATA_W + 2*FACTOR_LOG2, so no overflow is possible; result is always <= 2**DATA_W-1.
  - decimate result: acc.
- After WR:
  - clear acc, kx and ky;
  - advance ox, wrapping into oy;
  - if (ox,oy) was (OUT_DIM-1,OUT_DIM-1), go to DONE; else go to RD.
- Output timing:
  - average: F*F*(1+MEM_LAT)+1 cycles per output pixel;
  - decimate: 2+MEM_LAT cycles per output pixel.
- Address arithmetic is modulo 2**ADDR_W, so wrap-around is silent. Correct placement is the integrator's job.
- DONE: finish=1 and held while enable=1. When enable=0, go to IDLE with finish=0 on the next cycle. A re-run requires enable to go low, then high again.
- enable=0 in RD/WAIT/WR: abort to IDLE on that edge. No write is issued after the abort, and a write in flight in the current WR cycle still completes.
- read and write are never both high. Both are 0 in IDLE, WAIT and DONE.
- addr_out and dout hold their last values outside RD/WR.

Decomposition:
- Package ds_pkg holds:
  - the state enum (IDLE, RD, WAIT, WR, DONE);
  - mode constants MODE_AVG=0 and MODE_DEC=1;
  - a clog2-based width helper.
- Sub-module ds_addr_gen holds:
  - the kx/ky/ox/oy counters with wrap and last-flags;
  - the source and destination address computation.
- The FSM, accumulator and rounding stay in downsample_engine.

Test Plan:
- Basic 2x2 average: IMG_DIM=8, FACTOR_LOG2=1, MEM_LAT=1, source pixel = x+8y, raise enable. Expect:
  - 16 writes, to DST_BASE..DST_BASE+15;
  - output(0,0): (0+1+8+9+2)>>2 = 5;
  - finish rises exactly 16*9 cycles after the first RD.
- Rounding: block of 10,11,12,13 -> write value 12 (truncation would give 11). Block of 255 x4 -> 255, no overflow.
- Decimate: mode=1, same 8x8 image. Expect:
  - 16 writes, output(ox,oy) = 2*ox + 16*oy;
  - one read per output;
  - 3 cycles per output.
- Latency and factor: MEM_LAT=3, FACTOR_LOG2=2, IMG_DIM=8, constant source 7. Expect:
  - 4 writes of 7;
  - d_in captured exactly 3 cycles after each read strobe;
  - 65 cycles per output.
- Abort/reset: drop enable after the 5th write; separately, assert rst during WAIT. Expect:
  - no further write or read;
  - IDLE next cycle, with all outputs 0 after rst;
  - a fresh run then produces correct results from (0,0).
- Finish handshake: hold enable=1 after DONE. Expect:
  - finish stays 1 and no new reads;
  - when enable is deasserted, finish drops next cycle;
  - re-asserting enable starts a new full pass.

Source files
------------

// File: rtl/ds_pkg.sv
// Shared types and helpers for the hardwired downsampling engine.
package ds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_DONE
  } ds_state_t;

  localparam logic MODE_AVG = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int ds_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ds_addr_gen.sv
// Block/pixel position counters and the source/destination DRAM addresses
// derived from them. kx/ky walk inside an FxF block, ox/oy walk the output.
module ds_addr_gen
  import ds_pkg::*;
#(
  parameter int              ADDR_W      = 16,
  parameter int              IMG_DIM     = 128,
  parameter int              FACTOR_LOG2 = 1,
  parameter logic [ADDR_W-1:0] SRC_BASE  = 16'h0000,
  parameter logic [ADDR_W-1:0] DST_BASE  = 16'h4000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step_k,
  input  logic              step_o,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              k_last,
  output logic              o_last
);

  localparam int F       = 1 << FACTOR_LOG2;
  localparam int OUT_DIM = IMG_DIM >> FACTOR_LOG2;
  localparam int KW      = FACTOR_LOG2;
  localparam int OW      = ds_width(OUT_DIM);

  logic [KW-1:0] kx, ky;
  logic [OW-1:0] ox, oy;
  logic          kx_last, ky_last, ox_last, oy_last;

  assign kx_last = (kx == KW'(F - 1));
  assign ky_last = (ky == KW'(F - 1));
  assign ox_last = (ox == OW'(OUT_DIM - 1));
  assign oy_last = (oy == OW'(OUT_DIM - 1));
  assign k_last  = kx_last & ky_last;
  assign o_last  = ox_last & oy_last;

  // Step the in-block position after each read, and the output position after each write.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
    end else if (step_o) begin
      kx <= '0;
      ky <= '0;
      if (ox_last) begin
        ox <= '0;
        oy <= oy_last ? '0 : oy + 1'b1;
      end else begin
        ox <= ox + 1'b1;
      end
    end else if (step_k) begin
      if (kx_last) begin
        kx <= '0;
        ky <= ky + 1'b1;
      end else begin
        kx <= kx + 1'b1;
      end
    end
  end

  // Row-major addresses, wrapping silently modulo 2**ADDR_W.
  always_comb begin
    src_addr = SRC_BASE
             + (ADDR_W'(oy) * ADDR_W'(F) + ADDR_W'(ky)) * ADDR_W'(IMG_DIM)
             + ADDR_W'(ox) * ADDR_W'(F) + ADDR_W'(kx);
    dst_addr = DST_BASE + ADDR_W'(oy) * ADDR_W'(OUT_DIM) + ADDR_W'(ox);
  end

endmodule

// File: rtl/downsample_engine.sv
// Reduces each FxF block of a square DRAM image to one pixel (rounded
// average or top-left decimation) and writes the reduced image back.
module downsample_engine
  import ds_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 16,
  parameter int                IMG_DIM     = 128,
  parameter int                FACTOR_LOG2 = 1,
  parameter logic [ADDR_W-1:0] SRC_BASE    = 16'h0000,
  parameter logic [ADDR_W-1:0] DST_BASE    = 16'h4000,
  parameter int                MEM_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic [DATA_W-1:0] d_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] dout,
  output logic              read,
  output logic              write,
  output logic              busy,
  output logic              finish
);

  localparam int                SHIFT  = 2 * FACTOR_LOG2;
  localparam int                ACC_W  = DATA_W + SHIFT;
  localparam int                WAIT_W = ds_width(MEM_LAT);
  localparam logic [ACC_W-1:0]  HALF   = ACC_W'(1) << (SHIFT - 1);

  ds_state_t         state, next_state;
  logic              mode_q;
  logic [ACC_W-1:0]  acc;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] addr_hold, src_addr, dst_addr;
  logic [DATA_W-1:0] dout_hold, result;
  logic              wait_last, k_last, o_last;
  logic              clear, step_k, step_o;

  assign wait_last = (wait_cnt == WAIT_W'(MEM_LAT - 1));
  assign clear     = (state == ST_IDLE) && enable;
  assign step_k    = (state == ST_WAIT) && wait_last && (mode_q == MODE_AVG) && !k_last;
  assign step_o    = (state == ST_WR);
  assign result    = (mode_q == MODE_DEC) ? acc[DATA_W-1:0] : DATA_W'((acc + HALF) >> SHIFT);

  ds_addr_gen #(
    .ADDR_W      (ADDR_W),
    .IMG_DIM     (IMG_DIM),
    .FACTOR_LOG2 (FACTOR_LOG2),
    .SRC_BASE    (SRC_BASE),
    .DST_BASE    (DST_BASE)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .step_k   (step_k),
    .step_o   (step_o),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .k_last   (k_last),
    .o_last   (o_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Sequencing: reads per block, one write per output pixel, abort whenever enable drops.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (enable) next_state = ST_RD;
      ST_RD:   next_state = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!enable)        next_state = ST_IDLE;
        else if (wait_last) next_state = (mode_q == MODE_DEC || k_last) ? ST_WR : ST_RD;
      end
      ST_WR: begin
        if (!enable)     next_state = ST_IDLE;
        else if (o_last) next_state = ST_DONE;
        else             next_state = ST_RD;
      end
      ST_DONE: if (!enable) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Latency counter, accumulator and the last-driven bus values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_AVG;
      acc       <= '0;
      wait_cnt  <= '0;
      addr_hold <= '0;
      dout_hold <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            mode_q   <= mode;
            acc      <= '0;
            wait_cnt <= '0;
          end
        end
        ST_RD: begin
          wait_cnt  <= '0;
          addr_hold <= src_addr;
        end
        ST_WAIT: begin
          if (wait_last) begin
            wait_cnt <= '0;
            acc      <= (mode_q == MODE_DEC) ? ACC_W'(d_in) : acc + ACC_W'(d_in);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WR: begin
          addr_hold <= dst_addr;
          dout_hold <= result;
          acc       <= '0;
        end
        default: ;
      endcase
    end
  end

  // Bus strobes and status; address/data hold their last values outside RD/WR.
  always_comb begin
    read     = 1'b0;
    write    = 1'b0;
    busy     = 1'b0;
    finish   = 1'b0;
    addr_out = addr_hold;
    dout     = dout_hold;
    case (state)
      ST_RD: begin
        read     = 1'b1;
        busy     = 1'b1;
        addr_out = src_addr;
      end
      ST_WAIT: busy = 1'b1;
      ST_WR: begin
        write    = 1'b1;
        busy     = 1'b1;
        addr_out = dst_addr;
        dout     = result;
      end
      ST_DONE: finish = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_downsample_engine.sv
// Bench for downsample_engine: two instances (F=2/MEM_LAT=1 and F=4/MEM_LAT=3)
// on an 8x8 image, each checked every cycle against a cycle-offset model.
module tb_downsample_engine;

  localparam int          IMG = 8;
  localparam logic [15:0] DST = 16'h4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s    [2];
  logic        enable_s [2];
  logic        mode_s   [2];
  logic [7:0]  d_in_s   [2];
  logic [7:0]  dout_s   [2];
  logic [15:0] addr_s   [2];
  logic        read_s   [2];
  logic        write_s  [2];
  logic        busy_s   [2];
  logic        finish_s [2];

  downsample_engine #(
    .DATA_W(8), .ADDR_W(16), .IMG_DIM(8), .FACTOR_LOG2(1),
    .SRC_BASE(16'h0000), .DST_BASE(16'h4000), .MEM_LAT(1)
  ) dut_a (
    .clk(clk), .rst(rst_s[0]), .enable(enable_s[0]), .mode(mode_s[0]),
    .d_in(d_in_s[0]), .addr_out(addr_s[0]), .dout(dout_s[0]),
    .read(read_s[0]), .write(write_s[0]), .busy(busy_s[0]), .finish(finish_s[0])
  );

  downsample_engine #(
    .DATA_W(8), .ADDR_W(16), .IMG_DIM(8), .FACTOR_LOG2(2),
    .SRC_BASE(16'h0000), .DST_BASE(16'h4000), .MEM_LAT(3)
  ) dut_b (
    .clk(clk), .rst(rst_s[1]), .enable(enable_s[1]), .mode(mode_s[1]),
    .d_in(d_in_s[1]), .addr_out(addr_s[1]), .dout(dout_s[1]),
    .read(read_s[1]), .write(write_s[1]), .busy(busy_s[1]), .finish(finish_s[1])
  );

  logic [7:0] mem [2][64];
  logic       pv  [2][3];
  logic [7:0] pd  [2][3];

  logic        run_m  [2];
  int          cyc_m  [2];
  logic        dec_m  [2];
  logic [15:0] hold_a [2];
  logic [7:0]  hold_d [2];
  int          wr_log [2][16];
  int          wr_count [2];

  int checks   = 0;
  int passes   = 0;
  int cycle_no = 0;

  function automatic int mlOf(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int fOf(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic logic [7:0] memAt(input int i, input logic [15:0] a);
    return (a < 16'd64) ? mem[i][a[5:0]] : 8'hEE;
  endfunction

  // DRAM model: data for a read appears on d_in exactly MEM_LAT cycles later, noise otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int s = 2; s > 0; s--) begin
        pv[i][s] <= pv[i][s-1];
        pd[i][s] <= pd[i][s-1];
      end
      pv[i][0] <= read_s[i];
      pd[i][0] <= memAt(i, addr_s[i]);
      if (mlOf(i) == 1) d_in_s[i] <= (read_s[i] === 1'b1) ? memAt(i, addr_s[i]) : 8'($urandom);
      else              d_in_s[i] <= (pv[i][1] === 1'b1) ? pd[i][1] : 8'($urandom);
    end
  end

  function automatic int blockValue(input int i, input int ox, input int oy, input logic dec);
    int f, sum;
    f = fOf(i);
    sum = 0;
    if (dec) return int'(mem[i][oy*f*IMG + ox*f]);
    for (int ky = 0; ky < f; ky++)
      for (int kx = 0; kx < f; kx++)
        sum += int'(mem[i][(oy*f + ky)*IMG + ox*f + kx]);
    return (sum + f*f/2) / (f*f);
  endfunction

  // Expected bus activity c cycles after the first read of a pass.
  function automatic void expectAt(input int i, input int c, input logic dec,
                                   output logic rd, output logic wr, output logic bz,
                                   output logic fn, output int ea, output int ev);
    int f, ml, od, per, total, p, r, k;
    f = fOf(i);
    ml = mlOf(i);
    od = IMG / f;
    per = dec ? (2 + ml) : (f*f*(1 + ml) + 1);
    total = od * od * per;
    rd = 1'b0; wr = 1'b0; bz = 1'b0; fn = 1'b0; ea = -1; ev = -1;
    if (c >= total) begin
      fn = 1'b1;
      return;
    end
    bz = 1'b1;
    p = c / per;
    r = c % per;
    if (r == per - 1) begin
      wr = 1'b1;
      ea = int'(DST) + p;
      ev = blockValue(i, p % od, p / od, dec);
    end else begin
      k = r / (1 + ml);
      if (r % (1 + ml) == 0) begin
        rd = 1'b1;
        ea = ((p / od)*f + k / f)*IMG + (p % od)*f + k % f;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s[%0d] cycle %0d: got %0h, expected %0h",
                  name, inst, cycle_no, actual, expected);
  endtask

  // One clock: advance the model on the rising edge, compare both DUTs on the falling edge.
  task automatic tick();
    logic rd, wr, bz, fn;
    int   ea, ev, idx;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst_s[i]) begin
        run_m[i]  = 1'b0;
        hold_a[i] = '0;
        hold_d[i] = '0;
      end else if (!run_m[i]) begin
        if (enable_s[i]) begin
          run_m[i]    = 1'b1;
          cyc_m[i]    = 0;
          dec_m[i]    = mode_s[i];
          wr_count[i] = 0;
          for (int n = 0; n < 16; n++) wr_log[i][n] = -1;
        end
      end else if (!enable_s[i]) begin
        run_m[i] = 1'b0;
      end else begin
        cyc_m[i]++;
      end
    end
    @(negedge clk);
    cycle_no++;
    for (int i = 0; i < 2; i++) begin
      if (run_m[i]) expectAt(i, cyc_m[i], dec_m[i], rd, wr, bz, fn, ea, ev);
      else begin
        rd = 1'b0; wr = 1'b0; bz = 1'b0; fn = 1'b0; ea = -1; ev = -1;
      end
      if (!rd && !wr) ea = int'(hold_a[i]);
      if (!wr)        ev = int'(hold_d[i]);
      checkOutput("read",     i, 32'(read_s[i]),   32'(rd));
      checkOutput("write",    i, 32'(write_s[i]),  32'(wr));
      checkOutput("busy",     i, 32'(busy_s[i]),   32'(bz));
      checkOutput("finish",   i, 32'(finish_s[i]), 32'(fn));
      checkOutput("addr_out", i, 32'(addr_s[i]),   ea);
      checkOutput("dout",     i, 32'(dout_s[i]),   ev);
      if (rd || wr) hold_a[i] = 16'(ea);
      if (wr)       hold_d[i] = 8'(ev);
      if (write_s[i] === 1'b1) begin
        idx = int'(addr_s[i]) - int'(DST);
        if (idx >= 0 && idx < 16) wr_log[i][idx] = int'(dout_s[i]);
        wr_count[i]++;
      end
    end
  endtask

  task automatic fillRamp(input int i);
    for (int a = 0; a < 64; a++) mem[i][a] = 8'(a);
  endtask

  task automatic fillConst(input int i, input logic [7:0] v);
    for (int a = 0; a < 64; a++) mem[i][a] = v;
  endtask

  task automatic fillRandom(input int i);
    for (int a = 0; a < 64; a++) mem[i][a] = 8'($urandom);
  endtask

  // Runs one pass; optionally aborts after a given write, otherwise holds enable in DONE for a while.
  task automatic applyStimulus(input int i, input logic dec, input int abort_after,
                               input int hold, output int lat);
    int   first, seen_w;
    logic done;
    first = -1;
    seen_w = 0;
    done = 1'b0;
    lat = -1;
    mode_s[i] = dec;
    enable_s[i] = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      mode_s[i] = ~dec;
      if (read_s[i] === 1'b1 && first < 0) first = cycle_no;
      if (write_s[i] === 1'b1) seen_w++;
      if (abort_after > 0 && seen_w == abort_after) begin
        enable_s[i] = 1'b0;
        done = 1'b1;
        break;
      end
      if (finish_s[i] === 1'b1) begin
        lat = cycle_no - first;
        done = 1'b1;
        break;
      end
    end
    checkOutput("run_completes", i, 32'(done), 32'd1);
    if (abort_after == 0) begin
      for (int n = 0; n < hold; n++) tick();
      enable_s[i] = 1'b0;
    end
    for (int n = 0; n < 4; n++) tick();
  endtask

  int   lat;
  logic found;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1;
      enable_s[i] = 1'b0;
      mode_s[i] = 1'b0;
      run_m[i] = 1'b0;
      hold_a[i] = '0;
      hold_d[i] = '0;
      wr_count[i] = 0;
      for (int n = 0; n < 16; n++) wr_log[i][n] = -1;
      fillConst(i, 8'd0);
    end
    tick();
    tick();
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    tick();

    $display("[TB] 2x2 average on ramp image");
    fillRamp(0);
    applyStimulus(0, 1'b0, 0, 3, lat);
    checkOutput("avg_finish_latency", 0, lat, 144);
    checkOutput("avg_write_count",    0, wr_count[0], 16);
    checkOutput("avg_pix0",           0, wr_log[0][0], 5);
    checkOutput("avg_pix15",          0, wr_log[0][15], 59);

    $display("[TB] rounding and saturation blocks");
    fillRandom(0);
    mem[0][0] = 8'd10; mem[0][1] = 8'd11; mem[0][8] = 8'd12; mem[0][9] = 8'd13;
    mem[0][2] = 8'd255; mem[0][3] = 8'd255; mem[0][10] = 8'd255; mem[0][11] = 8'd255;
    applyStimulus(0, 1'b0, 0, 1, lat);
    checkOutput("round_half_up", 0, wr_log[0][0], 12);
    checkOutput("max_block",     0, wr_log[0][1], 255);

    $display("[TB] decimate on ramp image");
    fillRamp(0);
    applyStimulus(0, 1'b1, 0, 2, lat);
    checkOutput("dec_finish_latency", 0, lat, 48);
    checkOutput("dec_write_count",    0, wr_count[0], 16);
    checkOutput("dec_pix5",           0, wr_log[0][5], 18);
    checkOutput("dec_pix15",          0, wr_log[0][15], 54);

    $display("[TB] 4x4 average with MEM_LAT=3");
    fillConst(1, 8'd7);
    applyStimulus(1, 1'b0, 0, 2, lat);
    checkOutput("f4_finish_latency", 1, lat, 260);
    checkOutput("f4_write_count",    1, wr_count[1], 4);
    checkOutput("f4_pix0",           1, wr_log[1][0], 7);
    checkOutput("f4_pix3",           1, wr_log[1][3], 7);

    $display("[TB] abort after fifth write, then fresh run");
    fillRamp(0);
    applyStimulus(0, 1'b0, 5, 0, lat);
    for (int n = 0; n < 6; n++) tick();
    checkOutput("abort_write_count", 0, wr_count[0], 5);
    applyStimulus(0, 1'b0, 0, 1, lat);
    checkOutput("rerun_write_count", 0, wr_count[0], 16);
    checkOutput("rerun_pix0",        0, wr_log[0][0], 5);

    $display("[TB] reset during WAIT, then fresh run");
    fillRandom(1);
    mode_s[1] = 1'b0;
    enable_s[1] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (read_s[1] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("read_before_reset", 1, 32'(found), 32'd1);
    tick();
    rst_s[1] = 1'b1;
    enable_s[1] = 1'b0;
    tick();
    rst_s[1] = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    applyStimulus(1, 1'b0, 0, 1, lat);
    checkOutput("post_reset_latency", 1, lat, 260);

    $display("[TB] randomized passes");
    for (int r = 0; r < 10; r++) begin
      int   i, ab;
      logic dec;
      i = int'($urandom_range(0, 1));
      dec = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      fillRandom(i);
      applyStimulus(i, dec, ab, int'($urandom_range(0, 4)), lat);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
